main_control_fsm: RTL and testbench

//  Multicycle main control unit for the RV32I-subset core. Decodes opcode/funct3/funct7[5] from the

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/alu_funct_encoder.sv | 42 ++++
 rtl/main_control_fsm.sv | 145 ++++++++++++++
 tb/tb_main_control_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main control unit: FSM states, opcodes,
// ALU operation/function codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000100;
  localparam logic [5:0] FN_OR  = 6'b000101;
  localparam logic [5:0] FN_XOR = 6'b001010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RS1 = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/alu_funct_encoder.sv
// Maps {is_rtype, funct7_b5, funct3} onto the 6-bit alu_funct code and flags
// combinations the core does not implement.
module alu_funct_encoder
  import ctrl_pkg::*;
(
  input  logic       is_rtype,
  input  logic       funct7_b5,
  input  logic [2:0] funct3,
  output logic [5:0] alu_funct,
  output logic       valid
);

  always_comb begin
    alu_funct = '0;
    valid     = 1'b0;
    case (funct3)
      F3_ADDSUB: begin
        valid     = 1'b1;
        alu_funct = (is_rtype && funct7_b5) ? FN_SUB : FN_ADD;
      end
      F3_AND: begin
        valid     = 1'b1;
        alu_funct = FN_AND;
      end
      F3_OR: begin
        valid     = 1'b1;
        alu_funct = FN_OR;
      end
      F3_XOR: begin
        valid     = 1'b1;
        alu_funct = FN_XOR;
      end
      default: ;
    endcase
    // For R-type, funct7[5] is only meaningful as the sub selector.
    if (is_rtype && funct7_b5 && funct3 != F3_ADDSUB) begin
      valid     = 1'b0;
      alu_funct = '0;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM for the RV32I-subset core: Moore outputs decoded
// from the state register, with IR/PC load in FETCH gated by mem_ready.
module main_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [5:0] alu_funct,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       is_rtype;
  logic [5:0] enc_funct;
  logic       enc_valid;

  // zero is consumed by the datapath's PC-write gating, not by the FSM.
  logic unused_zero;
  assign unused_zero = zero;

  assign is_rtype = (opcode == OP_RTYPE);

  alu_funct_encoder u_enc (
    .is_rtype  (is_rtype),
    .funct7_b5 (funct7_b5),
    .funct3    (funct3),
    .alu_funct (enc_funct),
    .valid     (enc_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
          // Non-beq branches trap here so no PC side effect is ever issued.
          OP_BRANCH: state_d = (funct3 == F3_BEQ) ? S_BRANCH : S_TRAP;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC:      state_d = enc_valid ? S_ALU_WB : S_TRAP;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_OP_ADD;
    alu_funct     = '0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM;
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = is_rtype ? SRCB_RS2 : SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
        alu_funct = enc_funct;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: the driver walks each instruction
// through its phase list and queues the expected outputs; a monitor compares.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op, wb_sel;
  logic       alu_src_a, reg_write, illegal;
  logic [5:0] alu_funct;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_funct(alu_funct), .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_MADDR, P_MREAD, P_MWB, P_MWRITE,
                    P_EXEC, P_ALUWB, P_BRANCH, P_JAL, P_TRAP} phase_t;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic [5:0] alu_funct;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } outv_t;

  typedef struct {
    outv_t  v;
    bit     dc_funct;
    phase_t p;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_b5;
  bit         load_pending = 0;

  // Returns {valid, alu_funct} for an R/I ALU instruction.
  function automatic logic [6:0] ref_alu(bit r, bit b5, logic [2:0] f3);
    if (r && b5 && f3 != 3'b000) return 7'b0;
    case (f3)
      3'b000:  return (r && b5) ? 7'b1_000010 : 7'b1_000000;
      3'b111:  return 7'b1_000100;
      3'b110:  return 7'b1_000101;
      3'b100:  return 7'b1_001010;
      default: return 7'b0;
    endcase
  endfunction

  function automatic outv_t expect_out(phase_t p, bit mr);
    outv_t      o = '0;
    logic [6:0] a;
    case (p)
      P_FETCH: begin
        o.mem_req = 1; o.alu_src_b = 2'b01;
        o.ir_write = mr; o.pc_write = mr;
      end
      P_DECODE: o.alu_src_b = 2'b10;
      P_MADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MREAD:  begin o.mem_req = 1; o.iord = 1; end
      P_MWB:    begin o.reg_write = 1; o.wb_sel = 2'b01; end
      P_MWRITE: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
      P_EXEC: begin
        a = ref_alu(cur_op == 7'b0110011, cur_b5, cur_f3);
        o.alu_src_a = 1; o.alu_op = 2'b10;
        o.alu_src_b = (cur_op == 7'b0110011) ? 2'b00 : 2'b10;
        o.alu_funct = a[5:0];
      end
      P_ALUWB:  o.reg_write = 1;
      P_BRANCH: begin
        o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01;
      end
      P_JAL: begin
        o.reg_write = 1; o.wb_sel = 2'b10; o.pc_write = 1; o.pc_source = 2'b10;
      end
      P_TRAP:  o.illegal = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic push_exp(phase_t p, bit mr);
    exp_t       e;
    logic [6:0] a;
    a = ref_alu(cur_op == 7'b0110011, cur_b5, cur_f3);
    e.v = expect_out(p, mr);
    e.dc_funct = (p == P_EXEC) && !a[6];
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic cycle(phase_t p, bit mr);
    @(negedge clk);
    mem_ready = mr;
    zero = 1'($urandom_range(0, 1));
    if (load_pending) begin
      opcode = cur_op; funct3 = cur_f3; funct7_b5 = cur_b5;
      load_pending = 0;
    end
    #1 push_exp(p, mr);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst_n = 0; mem_ready = 0;
    #1 push_exp(P_IDLE, 0);
    @(negedge clk);
    #1 push_exp(P_IDLE, 0);
    @(negedge clk);
    rst_n = 1;
    #1 push_exp(P_IDLE, 0);
  endtask

  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic b5, int rd_stall);
    phase_t     ph[$];
    logic [6:0] a;
    int         n;
    cur_op = op; cur_f3 = f3; cur_b5 = b5; load_pending = 1;
    a = ref_alu(op == 7'b0110011, b5, f3);
    ph = '{P_FETCH, P_DECODE};
    case (op)
      7'b0000011: ph = {ph, P_MADDR, P_MREAD, P_MWB};
      7'b0100011: ph = {ph, P_MADDR, P_MWRITE};
      7'b0110011, 7'b0010011: ph = {ph, P_EXEC, (a[6] ? P_ALUWB : P_TRAP)};
      7'b1100011: ph.push_back((f3 == 3'b000) ? P_BRANCH : P_TRAP);
      7'b1101111: ph.push_back(P_JAL);
      default:    ph.push_back(P_TRAP);
    endcase
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH || ph[i] == P_MREAD || ph[i] == P_MWRITE) begin
        n = (ph[i] == P_MREAD && rd_stall >= 0) ? rd_stall : int'($urandom_range(0, 2));
        repeat (n) cycle(ph[i], 0);
        cycle(ph[i], 1);
      end else if (ph[i] == P_TRAP) begin
        repeat (4) cycle(P_TRAP, 1'($urandom_range(0, 1)));
        reset_seq();
      end else begin
        cycle(ph[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation.
  initial begin
    exp_t  e;
    outv_t act;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = '{mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, alu_op, alu_funct, reg_write, wb_sel, illegal};
        if (e.dc_funct) act.alu_funct = e.v.alu_funct;
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s @%0t: outputs got %b expected %b", e.p.name(), $time, act, e.v);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         k;
    rst_n = 0; opcode = '0; funct3 = '0; funct7_b5 = 0; zero = 0; mem_ready = 0;
    cur_op = '0; cur_f3 = '0; cur_b5 = 0;
    @(negedge clk);
    #1 push_exp(P_IDLE, 0);
    @(negedge clk);
    rst_n = 1;
    #1 push_exp(P_IDLE, 0);

    run_instr(7'b0110011, 3'b000, 0, -1);  // add
    run_instr(7'b0110011, 3'b000, 1, -1);  // sub
    run_instr(7'b0110011, 3'b100, 0, -1);  // xor
    run_instr(7'b0010011, 3'b110, 1, -1);  // ori, b5 ignored
    run_instr(7'b0000011, 3'b010, 0, 3);   // load, 3-cycle stall
    run_instr(7'b0100011, 3'b010, 0, -1);  // store
    run_instr(7'b1100011, 3'b000, 0, -1);  // beq
    run_instr(7'b1101111, 3'b000, 0, -1);  // jal
    run_instr(7'b1110011, 3'b000, 0, -1);  // system -> trap
    run_instr(7'b0110011, 3'b111, 1, -1);  // bad R funct -> trap

    cur_op = 7'b0110011; cur_f3 = 3'b000; cur_b5 = 0; load_pending = 1;
    cycle(P_FETCH, 0);
    cycle(P_FETCH, 0);
    reset_seq();

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 19);
      f3 = 3'($urandom);
      case (k)
        0, 1, 2, 3: op = 7'b0110011;
        4, 5, 6:    op = 7'b0010011;
        7, 8, 9:    op = 7'b0000011;
        10, 11:     op = 7'b0100011;
        12, 13, 14: begin op = 7'b1100011; f3 = 3'b000; end
        15, 16:     op = 7'b1101111;
        default: begin
          op = 7'($urandom);
          if (op == 7'b1100011) f3 = 3'b000;
        end
      endcase
      run_instr(op, f3, 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
